// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC front end.
// Angles are binary: the full circle is 2^CORDIC_ANGLE_W and wraps.
package cordic_pkg;

    localparam int unsigned CORDIC_XY_W    = 16;
    localparam int unsigned CORDIC_ANGLE_W = 32;

    localparam logic [CORDIC_ANGLE_W-1:0] ANGLE_PI      = {1'b1, {(CORDIC_ANGLE_W-1){1'b0}}};
    localparam logic [CORDIC_ANGLE_W-1:0] ANGLE_HALF_PI = {2'b01, {(CORDIC_ANGLE_W-2){1'b0}}};

    typedef enum logic {
        CORDIC_ROT = 1'b0,
        CORDIC_VEC = 1'b1
    } cordic_mode_e;

    typedef struct packed {
        logic signed [CORDIC_XY_W-1:0] x;
        logic signed [CORDIC_XY_W-1:0] y;
        logic [CORDIC_ANGLE_W-1:0]     z;
        cordic_mode_e                  mode;
        logic                          flipped;
        logic                          sat_err;
    } cordic_req_t;

    // Returns {saturated, -v}; the most negative value maps to the most positive one.
    function automatic logic [CORDIC_XY_W:0] sat_neg(input logic signed [CORDIC_XY_W-1:0] v);
        if (v == {1'b1, {(CORDIC_XY_W-1){1'b0}}}) begin
            return {1'b1, 1'b0, {(CORDIC_XY_W-1){1'b1}}};
        end
        return {1'b0, -v};
    endfunction

endpackage

// File: rtl/cordic_skid_buf.sv
// Two-slot valid/ready skid buffer for an arbitrary packed payload.
// in_ready depends only on stored state; outputs read as zero while rst is high.
module cordic_skid_buf #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    T     out_q;
    T     skid_q;
    logic out_v_q;
    logic skid_v_q;
    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && !skid_v_q;
    assign out_fire = out_v_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            skid_q   <= '0;
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
        end else if (out_fire || !out_v_q) begin
            // OUT is free this edge: refill from SKID first, otherwise from the input.
            if (skid_v_q) begin
                out_q    <= skid_q;
                out_v_q  <= 1'b1;
                skid_v_q <= 1'b0;
            end else begin
                out_v_q <= in_fire;
                if (in_fire) begin
                    out_q <= in_data;
                end
            end
        end else if (in_fire) begin
            skid_q   <= in_data;
            skid_v_q <= 1'b1;
        end
    end

    assign in_ready  = !rst && !skid_v_q;
    assign out_valid = !rst && out_v_q;

    always_comb begin
        out_data = out_q;
        if (rst) begin
            out_data = '0;
        end
    end

endmodule

// File: rtl/cordic_range_reduce.sv
// Pre-rotates requests by pi when needed so the CORDIC core sees angles in
// [-pi/2, pi/2) and vectors with x >= 0, then buffers them in a skid stage.
module cordic_range_reduce
    import cordic_pkg::*;
#(
    parameter int unsigned XY_W    = CORDIC_XY_W,
    parameter int unsigned ANGLE_W = CORDIC_ANGLE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [XY_W-1:0]    x_in,
    input  logic [XY_W-1:0]    y_in,
    input  logic [ANGLE_W-1:0] z_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               mode_out,
    output logic [XY_W-1:0]    x_out,
    output logic [XY_W-1:0]    y_out,
    output logic [ANGLE_W-1:0] z_out,
    output logic               flipped,
    output logic               sat_err
);

    logic [ANGLE_W-1:0] z_shift;
    logic [XY_W:0]      x_neg;
    logic [XY_W:0]      y_neg;
    logic               flip;
    cordic_req_t        req;
    cordic_req_t        out_req;

    // z lies in [-pi/2, pi/2) exactly when z + pi/2 lands in [0, pi).
    assign z_shift = z_in + ANGLE_HALF_PI;
    assign x_neg   = sat_neg(x_in);
    assign y_neg   = sat_neg(y_in);

    always_comb begin
        flip = (mode == CORDIC_VEC) ? x_in[XY_W-1] : z_shift[ANGLE_W-1];

        req         = '0;
        req.mode    = cordic_mode_e'(mode);
        req.flipped = flip;
        req.x       = x_in;
        req.y       = y_in;
        req.z       = z_in;
        if (flip) begin
            req.x       = x_neg[XY_W-1:0];
            req.y       = y_neg[XY_W-1:0];
            req.z       = z_in + ANGLE_PI;
            req.sat_err = x_neg[XY_W] | y_neg[XY_W];
        end
    end

    cordic_skid_buf #(
        .T(cordic_req_t)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (req),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_req)
    );

    assign x_out    = out_req.x;
    assign y_out    = out_req.y;
    assign z_out    = out_req.z;
    assign mode_out = out_req.mode;
    assign flipped  = out_req.flipped;
    assign sat_err  = out_req.sat_err;

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Self-checking bench for cordic_range_reduce: directed vector table, back-pressure,
// mid-operation reset and a randomized stream checked against an arithmetic model.
module tb_cordic_range_reduce;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mode = 1'b0;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
    logic [31:0] z_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        mode_out;
    logic [15:0] x_out;
    logic [15:0] y_out;
    logic [31:0] z_out;
    logic        flipped;
    logic        sat_err;

    always #5 clk = ~clk;

    cordic_range_reduce #(
        .XY_W   (16),
        .ANGLE_W(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .x_in     (x_in),
        .y_in     (y_in),
        .z_in     (z_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mode_out (mode_out),
        .x_out    (x_out),
        .y_out    (y_out),
        .z_out    (z_out),
        .flipped  (flipped),
        .sat_err  (sat_err)
    );

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] z;
        logic        m;
        logic        f;
        logic        s;
    } beat_t;

    typedef struct {
        logic        m;
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] z;
        beat_t       exp;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    beat_t sbq[$];
    int    sent;
    int    recv;
    bit    prev_hold = 1'b0;
    beat_t prev_out;

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic string fmt(input beat_t b);
        return $sformatf("x=%h y=%h z=%h m=%0d f=%0d s=%0d", b.x, b.y, b.z, b.m, b.f, b.s);
    endfunction

    function automatic beat_t observed();
        beat_t b;
        b.x = x_out;
        b.y = y_out;
        b.z = z_out;
        b.m = mode_out;
        b.f = flipped;
        b.s = sat_err;
        return b;
    endfunction

    // Reference: decide the flip from the signed angle / signed x, then negate with clamping.
    function automatic beat_t model(input logic m, input logic [15:0] x, input logic [15:0] y,
                                   input logic [31:0] z);
        beat_t             e;
        longint            zs;
        longint            quarter;
        longint unsigned   zu;
        int                xi;
        int                yi;
        bit                flip;
        bit                sat;
        zs      = longint'($signed(z));
        quarter = 1073741824;
        xi      = $signed(x);
        yi      = $signed(y);
        if (m) flip = (xi < 0);
        else   flip = (zs < -quarter) || (zs >= quarter);
        sat = 1'b0;
        e.z = z;
        if (flip) begin
            xi = -xi;
            yi = -yi;
            if (xi > 32767) begin xi = 32767; sat = 1'b1; end
            if (yi > 32767) begin yi = 32767; sat = 1'b1; end
            zu  = {32'd0, z};
            zu  = (zu + 64'd2147483648) % 64'd4294967296;
            e.z = zu[31:0];
        end
        e.x = 16'(xi);
        e.y = 16'(yi);
        e.m = m;
        e.f = flip;
        e.s = sat;
        return e;
    endfunction

    function automatic logic [15:0] pick_xy();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h0000;
            2:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] pick_z();
        case ($urandom_range(0, 7))
            0:       return 32'h4000_0000;
            1:       return 32'hC000_0000;
            2:       return 32'h3FFF_FFFF;
            3:       return 32'hBFFF_FFFF;
            4:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One cycle: drive at negedge, evaluate handshakes just before the next posedge.
    task automatic step(input logic iv, input logic m, input logic [15:0] x, input logic [15:0] y,
                        input logic [31:0] z, input logic ordy);
        beat_t exp;
        @(negedge clk);
        in_valid  = iv;
        mode      = m;
        x_in      = x;
        y_in      = y;
        z_in      = z;
        out_ready = ordy;
        #4;
        if (prev_hold) begin
            check("hold_stable", out_valid && (observed() == prev_out),
                  $sformatf("got v=%0d %s want %s", out_valid, fmt(observed()), fmt(prev_out)));
        end
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("ghost_beat", 1'b0, $sformatf("got unexpected beat %s", fmt(observed())));
            end else begin
                exp = sbq.pop_front();
                check("beat", observed() == exp,
                      $sformatf("got %s want %s", fmt(observed()), fmt(exp)));
            end
            recv++;
        end
        if (in_valid && in_ready) begin
            sbq.push_back(model(m, x, y, z));
            sent++;
        end
        prev_hold = out_valid && !out_ready;
        prev_out  = observed();
    endtask

    vec_t  vecs[10];
    logic  bm[8];
    logic [15:0] bx[8];
    logic [15:0] by[8];
    logic [31:0] bz[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 16'h4000, 16'h0000, 32'h2000_0000, '{16'h4000, 16'h0000, 32'h2000_0000, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{1'b0, 16'h4000, 16'h0100, 32'h6000_0000, '{16'hC000, 16'hFF00, 32'hE000_0000, 1'b0, 1'b1, 1'b0}};
        vecs[2] = '{1'b1, 16'hF000, 16'h1000, 32'h0000_0000, '{16'h1000, 16'hF000, 32'h8000_0000, 1'b1, 1'b1, 1'b0}};
        vecs[3] = '{1'b1, 16'h0000, 16'h1234, 32'h0000_0000, '{16'h0000, 16'h1234, 32'h0000_0000, 1'b1, 1'b0, 1'b0}};
        vecs[4] = '{1'b0, 16'h8000, 16'h0000, 32'h8000_0000, '{16'h7FFF, 16'h0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1}};
        vecs[5] = '{1'b0, 16'h1234, 16'h5678, 32'hC000_0000, '{16'h1234, 16'h5678, 32'hC000_0000, 1'b0, 1'b0, 1'b0}};
        vecs[6] = '{1'b0, 16'h1234, 16'h5678, 32'h4000_0000, '{16'hEDCC, 16'hA988, 32'hC000_0000, 1'b0, 1'b1, 1'b0}};
        vecs[7] = '{1'b0, 16'h0001, 16'hFFFF, 32'hBFFF_FFFF, '{16'hFFFF, 16'h0001, 32'h3FFF_FFFF, 1'b0, 1'b1, 1'b0}};
        vecs[8] = '{1'b1, 16'hFFFF, 16'h8000, 32'h1234_5678, '{16'h0001, 16'h7FFF, 32'h9234_5678, 1'b1, 1'b1, 1'b1}};
        vecs[9] = '{1'b1, 16'h7FFF, 16'h8000, 32'h0000_0000, '{16'h7FFF, 16'h8000, 32'h0000_0000, 1'b1, 1'b0, 1'b0}};

        // Reset state
        repeat (2) @(negedge clk);
        #4;
        check("reset_outputs_zero",
              {in_ready, out_valid, x_out, y_out, z_out, mode_out, flipped, sat_err} == '0,
              $sformatf("got rdy=%0d v=%0d %s want all zero", in_ready, out_valid, fmt(observed())));
        @(negedge clk);
        rst = 1'b0;
        #4;
        check("ready_after_reset", in_ready && !out_valid,
              $sformatf("got rdy=%0d v=%0d want rdy=1 v=0", in_ready, out_valid));

        // Directed table, one beat per cycle with out_ready high
        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            mode      = vecs[i].m;
            x_in      = vecs[i].x;
            y_in      = vecs[i].y;
            z_in      = vecs[i].z;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), out_valid && (observed() == vecs[i].exp),
                  $sformatf("got v=%0d %s want v=1 %s", out_valid, fmt(observed()),
                            fmt(vecs[i].exp)));
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);

        // Back-pressure: 8 beats, out_ready low for 4 cycles mid-stream
        for (int i = 0; i < 8; i++) begin
            bm[i] = 1'($urandom);
            bx[i] = pick_xy();
            by[i] = pick_xy();
            bz[i] = pick_z();
        end
        sent = 0;
        recv = 0;
        prev_hold = 1'b0;
        for (int c = 0; c < 7; c++) begin
            int k;
            k = (sent < 8) ? sent : 0;
            step(sent < 8, bm[k], bx[k], by[k], bz[k], c < 3);
        end
        check("bp_buffered", sbq.size() == 2 && sent == 4,
              $sformatf("got held=%0d sent=%0d want held=2 sent=4", sbq.size(), sent));
        check("bp_in_ready_low", !in_ready && out_valid,
              $sformatf("got rdy=%0d v=%0d want rdy=0 v=1", in_ready, out_valid));
        for (int c = 0; c < 40 && recv < 8; c++) begin
            int k;
            k = (sent < 8) ? sent : 0;
            step(sent < 8, bm[k], bx[k], by[k], bz[k], 1'b1);
        end
        check("bp_all_delivered", recv == 8 && sent == 8 && sbq.size() == 0,
              $sformatf("got sent=%0d recv=%0d left=%0d want 8/8/0", sent, recv, sbq.size()));

        // Reset with both slots full
        step(1'b1, 1'b0, 16'h1111, 16'h2222, 32'h0000_0001, 1'b0);
        step(1'b1, 1'b1, 16'hF111, 16'h3333, 32'h0000_0002, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #4;
        check("rst_midop_outputs",
              {in_ready, out_valid, x_out, y_out, z_out, mode_out, flipped, sat_err} == '0,
              $sformatf("got rdy=%0d v=%0d %s want all zero", in_ready, out_valid, fmt(observed())));
        sbq.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #4;
        check("rst_midop_ready", in_ready && !out_valid,
              $sformatf("got rdy=%0d v=%0d want rdy=1 v=0", in_ready, out_valid));
        recv = 0;
        repeat (6) step(1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 1'b1);
        check("no_stale_beats", recv == 0, $sformatf("got %0d beats want 0", recv));

        // Randomized stream
        sent = 0;
        recv = 0;
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), pick_xy(), pick_xy(), pick_z(),
                 $urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 20 && sbq.size() != 0; c++) begin
            step(1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 1'b1);
        end
        check("rand_drained", sbq.size() == 0 && sent == recv && sent > 100,
              $sformatf("got sent=%0d recv=%0d left=%0d want all delivered", sent, recv,
                        sbq.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
